// File: rtl/ysyx_22040759_pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: EXE forward selects and MDU sequencing states.
// Pure definitions; no logic, no latency, no flow control.
package ysyx_22040759_pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_WS     = 2'b01;
    localparam logic [1:0] FWD_MS_ALU = 2'b10;
    localparam logic [1:0] FWD_MS_LD  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    // MEM outranks WB because it carries the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic ms_hit, input logic ms_ld, input logic ws_hit);
        if (ms_hit) begin
            return ms_ld ? FWD_MS_LD : FWD_MS_ALU;
        end else if (ws_hit) begin
            return FWD_WS;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/ysyx_22040759_pipe_ctrl_fwd.sv
// Combinational EXE operand forward selects and raw ID load-use hit detect.
// Zero latency; no flow control of its own (the caller masks the hit with the flush).
module ysyx_22040759_fwd_unit
    import ysyx_22040759_pipe_ctrl_pkg::*;
(
    input  logic       ds_valid_i,
    input  logic [4:0] ds_rs1_i,
    input  logic [4:0] ds_rs2_i,
    input  logic       ds_rs1_ren_i,
    input  logic       ds_rs2_ren_i,
    input  logic       es_valid_i,
    input  logic [4:0] es_rs1_i,
    input  logic [4:0] es_rs2_i,
    input  logic [4:0] es_rd_i,
    input  logic       es_mem_ren_i,
    input  logic       ms_valid_i,
    input  logic       ms_reg_wen_i,
    input  logic       ms_mem_ren_i,
    input  logic [4:0] ms_rd_i,
    input  logic       ws_valid_i,
    input  logic       ws_reg_wen_i,
    input  logic [4:0] ws_rd_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       load_use_o
);

    logic ms_wr;
    logic ws_wr;
    logic rs1_lu;
    logic rs2_lu;

    // x0 writes are architecturally discarded, so they must never be forwarded.
    assign ms_wr = ms_valid_i & ms_reg_wen_i & (ms_rd_i != 5'd0);
    assign ws_wr = ws_valid_i & ws_reg_wen_i & (ws_rd_i != 5'd0);

    assign fwd_a_o = fwd_sel(ms_wr & (ms_rd_i == es_rs1_i), ms_mem_ren_i, ws_wr & (ws_rd_i == es_rs1_i));
    assign fwd_b_o = fwd_sel(ms_wr & (ms_rd_i == es_rs2_i), ms_mem_ren_i, ws_wr & (ws_rd_i == es_rs2_i));

    assign rs1_lu     = ds_rs1_ren_i & (ds_rs1_i == es_rd_i);
    assign rs2_lu     = ds_rs2_ren_i & (ds_rs2_i == es_rd_i);
    assign load_use_o = ds_valid_i & es_valid_i & es_mem_ren_i & (es_rd_i != 5'd0) & (rs1_lu | rs2_lu);

endmodule

// File: rtl/ysyx_22040759_pipe_ctrl.sv
// Hazard/sequencing control: forwarding, load-use stall, MDU hold of EXE, fetch flush and stale-response discard.
// Forward/stall are combinational; MDU holds EXE (es_ready_go low) until its result is handed to MEM.
module ysyx_22040759_pipe_ctrl
    import ysyx_22040759_pipe_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ds_valid,
    input  logic [4:0] ds_rs1,
    input  logic [4:0] ds_rs2,
    input  logic       ds_rs1_ren,
    input  logic       ds_rs2_ren,
    input  logic       es_valid,
    input  logic [4:0] es_rs1,
    input  logic [4:0] es_rs2,
    input  logic [4:0] es_rd,
    input  logic       es_reg_wen,
    input  logic       es_mem_ren,
    input  logic       es_is_mdu,
    input  logic       ms_valid,
    input  logic       ms_reg_wen,
    input  logic       ms_mem_ren,
    input  logic [4:0] ms_rd,
    input  logic       ws_valid,
    input  logic       ws_reg_wen,
    input  logic [4:0] ws_rd,
    input  logic       ms_allowin,
    input  logic       br_taken,
    input  logic       if_req_fire,
    input  logic       if_resp_fire,
    input  logic       mdu_done,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       ds_stall,
    output logic       es_ready_go,
    output logic       mdu_start,
    output logic       flush_fd,
    output logic       if_resp_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             load_use;

    // Every load writes a register, so the EXE write-enable adds nothing to the load-use check.
    logic unused_es_reg_wen;
    assign unused_es_reg_wen = es_reg_wen;

    ysyx_22040759_fwd_unit u_fwd (
        .ds_valid_i  (ds_valid),
        .ds_rs1_i    (ds_rs1),
        .ds_rs2_i    (ds_rs2),
        .ds_rs1_ren_i(ds_rs1_ren),
        .ds_rs2_ren_i(ds_rs2_ren),
        .es_valid_i  (es_valid),
        .es_rs1_i    (es_rs1),
        .es_rs2_i    (es_rs2),
        .es_rd_i     (es_rd),
        .es_mem_ren_i(es_mem_ren),
        .ms_valid_i  (ms_valid),
        .ms_reg_wen_i(ms_reg_wen),
        .ms_mem_ren_i(ms_mem_ren),
        .ms_rd_i     (ms_rd),
        .ws_valid_i  (ws_valid),
        .ws_reg_wen_i(ws_reg_wen),
        .ws_rd_i     (ws_rd),
        .fwd_a_o     (ForwardA),
        .fwd_b_o     (ForwardB),
        .load_use_o  (load_use)
    );

    assign ds_stall    = load_use & ~br_taken;
    assign flush_fd    = br_taken;
    assign es_ready_go = ~es_is_mdu | ~es_valid | (state_q == MDU_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDU_IDLE;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_start = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (es_valid && es_is_mdu && !br_taken) begin
                    state_d   = MDU_BUSY;
                    mdu_start = ~rst;
                end
            end
            MDU_BUSY: if (mdu_done)   state_d = MDU_DONE;
            MDU_DONE: if (ms_allowin) state_d = MDU_IDLE;
            default:                  state_d = MDU_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (if_req_fire && !if_resp_fire && inflight_q != CNT_MAX) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!if_req_fire && if_resp_fire && inflight_q != '0) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // A response landing in the redirect cycle is already dropped, so it leaves the discard budget.
    always_comb begin
        discard_d = discard_q;
        if (br_taken) begin
            if (!if_resp_fire) begin
                discard_d = inflight_q;
            end else if (inflight_q != '0) begin
                discard_d = inflight_q - CNT_W'(1);
            end else begin
                discard_d = '0;
            end
        end else if (if_resp_fire && discard_q != '0) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    assign if_resp_drop = ~rst & if_resp_fire & ((discard_q != '0) | br_taken);

endmodule

// File: tb/tb_ysyx_22040759_pipe_ctrl.sv
// Directed bench for the pipeline hazard controller, checked every cycle against a spec-level model.
module tb_ysyx_22040759_pipe_ctrl;

    localparam int MAXO = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ds_valid = 0, ds_rs1_ren = 0, ds_rs2_ren = 0;
    logic [4:0] ds_rs1 = 0, ds_rs2 = 0;
    logic       es_valid = 0, es_reg_wen = 0, es_mem_ren = 0, es_is_mdu = 0;
    logic [4:0] es_rs1 = 0, es_rs2 = 0, es_rd = 0;
    logic       ms_valid = 0, ms_reg_wen = 0, ms_mem_ren = 0;
    logic [4:0] ms_rd = 0;
    logic       ws_valid = 0, ws_reg_wen = 0;
    logic [4:0] ws_rd = 0;
    logic       ms_allowin = 1, br_taken = 0, if_req_fire = 0, if_resp_fire = 0, mdu_done = 0;
    logic [1:0] ForwardA, ForwardB;
    logic       ds_stall, es_ready_go, mdu_start, flush_fd, if_resp_drop;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22040759_pipe_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .ds_valid(ds_valid), .ds_rs1(ds_rs1), .ds_rs2(ds_rs2),
        .ds_rs1_ren(ds_rs1_ren), .ds_rs2_ren(ds_rs2_ren),
        .es_valid(es_valid), .es_rs1(es_rs1), .es_rs2(es_rs2), .es_rd(es_rd),
        .es_reg_wen(es_reg_wen), .es_mem_ren(es_mem_ren), .es_is_mdu(es_is_mdu),
        .ms_valid(ms_valid), .ms_reg_wen(ms_reg_wen), .ms_mem_ren(ms_mem_ren), .ms_rd(ms_rd),
        .ws_valid(ws_valid), .ws_reg_wen(ws_reg_wen), .ws_rd(ws_rd),
        .ms_allowin(ms_allowin), .br_taken(br_taken),
        .if_req_fire(if_req_fire), .if_resp_fire(if_resp_fire), .mdu_done(mdu_done),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ds_stall(ds_stall),
        .es_ready_go(es_ready_go), .mdu_start(mdu_start),
        .flush_fd(flush_fd), .if_resp_drop(if_resp_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- spec-level model ----------------
    int m_inflight = 0;   // fetch requests still owed a response
    int m_discard  = 0;   // responses still to be thrown away
    bit m_busy     = 0;   // MDU launched, result not back yet
    bit m_held     = 0;   // MDU result back, waiting for MEM to take it

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (ms_valid && ms_reg_wen && ms_rd != 0 && ms_rd == rs) return ms_mem_ren ? 2'b11 : 2'b10;
        if (ws_valid && ws_reg_wen && ws_rd != 0 && ws_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        logic hit;
        hit = (ds_rs1_ren && ds_rs1 == es_rd) || (ds_rs2_ren && ds_rs2 == es_rd);
        return ds_valid && es_valid && es_mem_ren && es_rd != 0 && hit && !br_taken;
    endfunction

    function automatic logic exp_start();
        return !rst && !m_busy && !m_held && es_valid && es_is_mdu && !br_taken;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > MAXO) ? MAXO : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_inflight <= 0; m_discard <= 0; m_busy <= 0; m_held <= 0;
        end else begin
            if (br_taken) m_discard <= clamp(m_inflight - int'(if_resp_fire));
            else if (if_resp_fire && m_discard > 0) m_discard <= m_discard - 1;
            m_inflight <= clamp(m_inflight + int'(if_req_fire) - int'(if_resp_fire));
            if (exp_start()) m_busy <= 1;
            else if (m_busy && mdu_done) begin m_busy <= 0; m_held <= 1; end
            else if (m_held && ms_allowin) m_held <= 0;
        end
    end

    always @(negedge clk) begin
        chk("ForwardA", 32'(ForwardA), 32'(exp_fwd(es_rs1)));
        chk("ForwardB", 32'(ForwardB), 32'(exp_fwd(es_rs2)));
        chk("ds_stall", 32'(ds_stall), 32'(exp_stall()));
        chk("flush_fd", 32'(flush_fd), 32'(br_taken));
        chk("es_ready_go", 32'(es_ready_go), 32'(!(es_valid && es_is_mdu) || m_held));
        chk("mdu_start", 32'(mdu_start), 32'(exp_start()));
        chk("if_resp_drop", 32'(if_resp_drop), 32'(!rst && if_resp_fire && (m_discard != 0 || br_taken)));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ds_valid = 0; ds_rs1 = 0; ds_rs2 = 0; ds_rs1_ren = 0; ds_rs2_ren = 0;
        es_valid = 0; es_rs1 = 0; es_rs2 = 0; es_rd = 0; es_reg_wen = 0; es_mem_ren = 0; es_is_mdu = 0;
        ms_valid = 0; ms_reg_wen = 0; ms_mem_ren = 0; ms_rd = 0;
        ws_valid = 0; ws_reg_wen = 0; ws_rd = 0;
        ms_allowin = 1; br_taken = 0; if_req_fire = 0; if_resp_fire = 0; mdu_done = 0;
    endtask

    task automatic load_use_setup();
        clr();
        es_valid = 1; es_mem_ren = 1; es_reg_wen = 1; es_rd = 5'd7;
        ds_valid = 1; ds_rs1 = 5'd1; ds_rs1_ren = 1; ds_rs2 = 5'd7; ds_rs2_ren = 1;
    endtask

    initial begin
        int lows;
        int starts;
        // reset values
        tick(); tick();
        @(negedge clk);
        chk("rst_ForwardA", 32'(ForwardA), 0);
        chk("rst_ds_stall", 32'(ds_stall), 0);
        chk("rst_ready_go", 32'(es_ready_go), 1);
        chk("rst_mdu_start", 32'(mdu_start), 0);
        chk("rst_drop", 32'(if_resp_drop), 0);
        tick(); rst = 0;

        // forwarding priority and x0
        ms_valid = 1; ms_reg_wen = 1; ms_rd = 5'd5; ws_valid = 1; ws_reg_wen = 1; ws_rd = 5'd5;
        es_valid = 1; es_rs1 = 5'd5;
        @(negedge clk); chk("fwd_ms_alu", 32'(ForwardA), 32'h2);
        tick(); ms_rd = 0; ws_rd = 0; es_rs1 = 0;
        @(negedge clk); chk("fwd_x0", 32'(ForwardA), 32'h0);
        tick(); ms_rd = 5'd3; ws_rd = 5'd9; es_rs2 = 5'd9;
        @(negedge clk); chk("fwd_ws", 32'(ForwardB), 32'h1);
        tick(); ms_mem_ren = 1; ms_rd = 5'd9;
        @(negedge clk); chk("fwd_ms_ld", 32'(ForwardB), 32'h3);

        // load-use stall, then the load forwarded from MEM
        tick(); load_use_setup();
        @(negedge clk); chk("lu_stall", 32'(ds_stall), 1);
        tick(); clr();
        ms_valid = 1; ms_reg_wen = 1; ms_mem_ren = 1; ms_rd = 5'd7;
        es_valid = 1; es_rs1 = 5'd1; es_rs2 = 5'd7; es_rd = 5'd8;
        @(negedge clk);
        chk("lu_fwdB", 32'(ForwardB), 32'h3);
        chk("lu_stall_gone", 32'(ds_stall), 0);

        // flush beats load-use
        tick(); load_use_setup(); br_taken = 1;
        @(negedge clk);
        chk("flush_stall", 32'(ds_stall), 0);
        chk("flush_fd", 32'(flush_fd), 1);

        // MDU: four idle cycles between start and done, MEM refuses for 2 more cycles
        tick(); clr(); es_valid = 1; es_is_mdu = 1;
        lows = 0; starts = 0;
        for (int i = 0; i < 9; i++) begin
            mdu_done = (i == 5);
            ms_allowin = (i >= 8);
            @(negedge clk);
            if (!es_ready_go) lows++;
            if (mdu_start) starts++;
            tick();
        end
        clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mdu_start) starts++;
            tick();
        end
        chk("mdu_low_cycles", 32'(lows), 6);
        chk("mdu_starts", 32'(starts), 1);

        // two fetches in flight, redirect, three responses
        clr(); if_req_fire = 1; tick(); tick();
        if_req_fire = 0; br_taken = 1;
        @(negedge clk); chk("br_flush", 32'(flush_fd), 1);
        tick(); br_taken = 0; if_resp_fire = 1;
        @(negedge clk); chk("drop1", 32'(if_resp_drop), 1);
        tick(); @(negedge clk); chk("drop2", 32'(if_resp_drop), 1);
        tick(); @(negedge clk); chk("drop3", 32'(if_resp_drop), 0);

        // in-flight saturation, redirect coincident with a response
        tick(); clr(); if_req_fire = 1; tick(); tick(); tick();
        if_req_fire = 0; br_taken = 1; if_resp_fire = 1;
        @(negedge clk); chk("drop_br_coinc", 32'(if_resp_drop), 1);
        tick(); br_taken = 0;
        @(negedge clk); chk("drop_sat1", 32'(if_resp_drop), 1);
        tick(); @(negedge clk); chk("drop_sat2", 32'(if_resp_drop), 0);

        // reset mid-MDU, then a late mdu_done
        tick(); clr(); es_valid = 1; es_is_mdu = 1;
        @(negedge clk); chk("mdu_rst_start", 32'(mdu_start), 1);
        tick(); @(negedge clk); chk("mdu_rst_busy", 32'(es_ready_go), 0);
        tick(); rst = 1; es_valid = 0; es_is_mdu = 0;
        @(negedge clk);
        chk("mdu_rst_nostart", 32'(mdu_start), 0);
        chk("mdu_rst_rdy", 32'(es_ready_go), 1);
        tick(); rst = 0; mdu_done = 1;
        @(negedge clk); chk("mdu_late_done_rdy", 32'(es_ready_go), 1);
        tick(); mdu_done = 0; es_valid = 1; es_is_mdu = 1;
        @(negedge clk);
        chk("mdu_idle_restart", 32'(mdu_start), 1);
        chk("mdu_idle_rdy", 32'(es_ready_go), 0);
        tick(); clr();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
